// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request bus from the control unit plus RAM-side signals
interface mem_access_ctrl_if #(parameter int ADDR_W = 7);
  logic              Req;
  logic [5:0]        Req_Op;
  logic [31:0]       Req_Addr;
  logic [63:0]       Req_WData;
  logic              Busy;
  logic              MFC;
  logic              Trap;
  logic [63:0]       RData;
  logic [ADDR_W-1:0] MAR_Address;
  logic [31:0]       MDR_DataIn;
  logic [31:0]       MDR_DataOut;
  logic              Enable;
  logic [5:0]        OpCode;
  modport master (
    output Req, Req_Op, Req_Addr, Req_WData, MDR_DataOut,
    input  Busy, MFC, Trap, RData, MAR_Address, MDR_DataIn, Enable, OpCode
  );
  modport slave (
    input  Req, Req_Op, Req_Addr, Req_WData, MDR_DataOut,
    output Busy, MFC, Trap, RData, MAR_Address, MDR_DataIn, Enable, OpCode
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one request into RAM word accesses, splits LDD/STD, extends loads; define MISALIGN_TRAP_EN to trap misaligned addresses
module mem_access_ctrl #(
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 2
) (
  input logic Clk,
  input logic Reset,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACC, GAP, ACC2, DONE} st_t;
  st_t         state, nstate;
  logic [7:0]  cnt;
  logic [3:0]  op;
  logic [31:0] lo, w0, ext;
  logic        trap_r, legal, mis, bad, last, dbl, ld;
  assign legal = bus.Req_Op inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10};
`ifdef MISALIGN_TRAP_EN
  assign mis = bus.Req_Op[1:0] == 2'b10 ? bus.Req_Addr[0] :
               bus.Req_Op[1:0] == 2'b00 ? |bus.Req_Addr[1:0] :
               bus.Req_Op[1:0] == 2'b11 ? |bus.Req_Addr[2:0] : 1'b0;
`else
  assign mis = 1'b0;
`endif
  assign bad  = !legal || mis;
  assign last = cnt == 8'(LATENCY - 1);
  assign dbl  = op[1:0] == 2'b11;
  assign ld   = !op[2];
  assign ext  = op[1:0] == 2'b01 ? {{24{op[3] & bus.MDR_DataOut[7]}}, bus.MDR_DataOut[7:0]} :
                op[1:0] == 2'b10 ? {{16{op[3] & bus.MDR_DataOut[15]}}, bus.MDR_DataOut[15:0]} :
                bus.MDR_DataOut;
  // state register and per-access cycle counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= (state == ACC || state == ACC2) && !last ? cnt + 8'd1 : '0;
    end
  end
  // next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = bus.Req ? (bad ? DONE : ACC) : IDLE;
      ACC:     nstate = last ? (dbl ? GAP : DONE) : ACC;
      GAP:     nstate = ACC2;
      ACC2:    nstate = last ? DONE : ACC2;
      default: nstate = IDLE;
    endcase
  end
  // status outputs decoded from state
  always_comb begin
    bus.Busy   = state != IDLE;
    bus.MFC    = state == DONE;
    bus.Trap   = state == DONE && trap_r;
    bus.Enable = state == ACC || state == ACC2;
  end
  // request latch, RAM address/data sequencing and load result capture
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op              <= '0;
      lo              <= '0;
      w0              <= '0;
      trap_r          <= 1'b0;
      bus.MAR_Address <= '0;
      bus.MDR_DataIn  <= '0;
      bus.OpCode      <= '0;
      bus.RData       <= '0;
    end else begin
      if (state == IDLE && bus.Req) begin
        op              <= bus.Req_Op[3:0];
        lo              <= bus.Req_WData[31:0];
        trap_r          <= bad;
        bus.MAR_Address <= bus.Req_Addr[ADDR_W-1:0];
        bus.MDR_DataIn  <= bus.Req_Op == 6'd7 ? bus.Req_WData[63:32] : bus.Req_WData[31:0];
        bus.OpCode      <= legal && bus.Req_Op[1:0] == 2'b11 ? {3'b000, bus.Req_Op[2], 2'b00} : bus.Req_Op;
      end
      if (state == GAP) begin
        bus.MAR_Address <= bus.MAR_Address + ADDR_W'(4);
        if (op == 4'd7) bus.MDR_DataIn <= lo;
      end
      if (state == ACC && last && ld) begin
        if (dbl) w0 <= bus.MDR_DataOut;
        else bus.RData <= {32'h0, ext};
      end
      if (state == ACC2 && last && ld) bus.RData <= {w0, bus.MDR_DataOut};
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against a byte RAM model
module tb_mem_access_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  int total = 0, bad = 0;
  int lat, rises;
  logic [6:0] mar1, mar2;
  logic [31:0] mdr2;
  logic tr, seen;
  logic [7:0] mem [128];
  logic [6:0] a0, a1, a2, a3;
  mem_access_ctrl_if #(.ADDR_W(7)) bus();
  mem_access_ctrl #(.ADDR_W(7), .LATENCY(2)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  assign a0 = bus.MAR_Address;
  assign a1 = a0 + 7'd1;
  assign a2 = a0 + 7'd2;
  assign a3 = a0 + 7'd3;
  // big-endian byte RAM: byte/half reads right-justified
  always_comb begin
    bus.MDR_DataOut = {mem[a0], mem[a1], mem[a2], mem[a3]};
    if (bus.OpCode[1:0] == 2'b01) bus.MDR_DataOut = {24'h0, mem[a0]};
    else if (bus.OpCode[1:0] == 2'b10) bus.MDR_DataOut = {16'h0, mem[a0], mem[a1]};
  end
  always @(posedge clk) begin
    if (bus.Enable && bus.OpCode[2]) begin
      if (bus.OpCode[1:0] == 2'b00) begin
        mem[a0] <= bus.MDR_DataIn[31:24];
        mem[a1] <= bus.MDR_DataIn[23:16];
        mem[a2] <= bus.MDR_DataIn[15:8];
        mem[a3] <= bus.MDR_DataIn[7:0];
      end else if (bus.OpCode[1:0] == 2'b01) begin
        mem[a0] <= bus.MDR_DataIn[7:0];
      end else if (bus.OpCode[1:0] == 2'b10) begin
        mem[a0] <= bus.MDR_DataIn[15:8];
        mem[a1] <= bus.MDR_DataIn[7:0];
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic req(input logic [5:0] o, input logic [31:0] a, input logic [63:0] w);
    logic prev;
    @(negedge clk);
    bus.Req = 1'b1;
    bus.Req_Op = o;
    bus.Req_Addr = a;
    bus.Req_WData = w;
    lat = 0;
    rises = 0;
    prev = 1'b0;
    mar1 = '0;
    mar2 = '0;
    mdr2 = '0;
    do begin
      @(negedge clk);
      bus.Req = 1'b0;
      lat++;
      if (bus.Enable && !prev) begin
        rises++;
        if (rises == 1) mar1 = bus.MAR_Address;
        if (rises == 2) begin
          mar2 = bus.MAR_Address;
          mdr2 = bus.MDR_DataIn;
        end
      end
      prev = bus.Enable;
    end while (!bus.MFC && lat < 20);
    tr = bus.Trap;
  endtask
  initial begin
    bus.Req = 1'b0;
    bus.Req_Op = '0;
    bus.Req_Addr = '0;
    bus.Req_WData = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_mfc", bus.MFC, 0);
    chk("rst_trap", bus.Trap, 0);
    chk("rst_en", bus.Enable, 0);
    chk("rst_rdata", bus.RData, 0);
    chk("rst_ram", {bus.MAR_Address, bus.MDR_DataIn, bus.OpCode}, 0);
    rst = 1'b0;
    @(negedge clk);
    bus.Req = 1'b1;
    bus.Req_Op = 6'd1;
    bus.Req_Addr = 32'h10;
    bus.Req_WData = 64'h5555;
    @(negedge clk);
    bus.Req = 1'b0;
    chk("mid_en", bus.Enable, 1);
    chk("mid_busy", bus.Busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_en", bus.Enable, 0);
    chk("abort_busy", bus.Busy, 0);
    chk("abort_ram", {bus.MAR_Address, bus.MDR_DataIn, bus.OpCode}, 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= bus.MFC;
    end
    chk("abort_nomfc", seen, 0);
    req(6'd4, 32'h10, 64'h12345678);
    chk("st_lat", lat, 3);
    chk("st_trap", tr, 0);
    chk("st_mar", mar1, 7'h10);
    chk("st_rdata", bus.RData, 0);
    req(6'd0, 32'h10, 64'h0);
    chk("ld_lat", lat, 3);
    chk("ld_rdata", bus.RData, 64'h12345678);
    req(6'd5, 32'h20, 64'h80);
    chk("stb_lat", lat, 3);
    req(6'd9, 32'h20, 64'h0);
    chk("ldsb", bus.RData, 64'hFFFFFF80);
    req(6'd1, 32'h20, 64'h0);
    chk("ldub", bus.RData, 64'h80);
    req(6'd6, 32'h22, 64'h8001);
    req(6'd10, 32'h22, 64'h0);
    chk("ldsh", bus.RData, 64'hFFFF8001);
    req(6'd2, 32'h22, 64'h0);
    chk("lduh", bus.RData, 64'h8001);
    req(6'd7, 32'h7C, 64'hAABBCCDD_11223344);
    chk("std_lat", lat, 6);
    chk("std_rises", rises, 2);
    chk("std_mar1", mar1, 7'h7C);
    chk("std_mar2", mar2, 7'h00);
    chk("std_mdr2", mdr2, 32'h11223344);
    chk("std_rdata", bus.RData, 64'h8001);
    req(6'd3, 32'h7C, 64'h0);
    chk("ldd_lat", lat, 6);
    chk("ldd_rises", rises, 2);
    chk("ldd_rdata", bus.RData, 64'hAABBCCDD_11223344);
    req(6'b111111, 32'h10, 64'h0);
    chk("ill_lat", lat, 1);
    chk("ill_trap", tr, 1);
    chk("ill_en", rises, 0);
    chk("ill_rdata", bus.RData, 64'hAABBCCDD_11223344);
    req(6'd0, 32'h02, 64'h0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_trap", tr, 1);
    chk("mis_en", rises, 0);
    chk("mis_lat", lat, 1);
`else
    chk("mis_trap", tr, 0);
    chk("mis_en", rises, 1);
    chk("mis_mar", mar1, 7'h02);
    chk("mis_lat", lat, 3);
`endif
    @(negedge clk);
    chk("idle_busy", bus.Busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
